// File: rtl/apu_pkg.sv
// Shared APU definitions: length-counter lookup, frame-sequencer tick counts,
// register select codes and frame-sequence mode encoding.
package apu_pkg;

    localparam logic [15:0] TICK_QF1       = 16'd7457;
    localparam logic [15:0] TICK_HF1       = 16'd14913;
    localparam logic [15:0] TICK_QF3       = 16'd22371;
    localparam logic [15:0] TICK_END_4STEP = 16'd29829;
    localparam logic [15:0] TICK_END_5STEP = 16'd37281;

    typedef enum logic [1:0] {
        REG_LINEAR   = 2'd0,
        REG_UNUSED   = 2'd1,
        REG_TIMER_LO = 2'd2,
        REG_LEN_HI   = 2'd3
    } reg_addr_e;

    typedef enum logic {
        SEQ_4STEP = 1'b0,
        SEQ_5STEP = 1'b1
    } seq_mode_e;

    localparam logic [7:0] LEN_TABLE [0:31] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        return LEN_TABLE[idx];
    endfunction

endpackage

// File: rtl/apu_frame_seq.sv
// APU frame sequencer: free-running cycle counter producing registered
// quarter-frame and half-frame ticks in 4-step or 5-step mode.
module apu_frame_seq
    import apu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic frame_mode,
    output logic qf,
    output logic hf
);

    logic [15:0] cnt;
    logic [15:0] last;
    seq_mode_e   mode_q;
    seq_mode_e   mode_eff;
    logic        q_hit;
    logic        h_hit;

    // The mode input is only honoured on the count-0 cycle; elsewhere the
    // mode latched at the start of the sequence governs.
    always_comb begin
        mode_eff = (cnt == '0) ? seq_mode_e'(frame_mode) : mode_q;
        last     = (mode_eff == SEQ_5STEP) ? TICK_END_5STEP : TICK_END_4STEP;
        h_hit    = (cnt == TICK_HF1) || (cnt == last);
        q_hit    = h_hit || (cnt == TICK_QF1) || (cnt == TICK_QF3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            mode_q <= SEQ_4STEP;
            qf     <= 1'b0;
            hf     <= 1'b0;
        end else begin
            cnt    <= (cnt == last) ? '0 : cnt + 16'd1;
            mode_q <= mode_eff;
            qf     <= q_hit;
            hf     <= h_hit;
        end
    end

endmodule

// File: rtl/tri_gate_ctrl.sv
// Triangle channel gating: register file, linear counter, length counter and
// the step-enable gate, clocked by the shared frame sequencer ticks.
module tri_gate_ctrl
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       ch_en,
    input  logic       frame_mode,
    output logic [7:0] r1,
    output logic [7:0] r3,
    output logic [7:0] r4,
    output logic       step_en,
    output logic       len_active,
    output logic       qf,
    output logic       hf,
    output logic [6:0] lin_cnt
);

    reg_addr_e  addr;
    logic       wr_len;
    logic [7:0] len_cnt;
    logic [7:0] len_next;
    logic [6:0] lin_next;
    logic       reload_flag;
    logic       reload_next;

    apu_frame_seq u_frame_seq (
        .clk        (clk),
        .reset      (reset),
        .frame_mode (frame_mode),
        .qf         (qf),
        .hf         (hf)
    );

    // All counter decisions use the pre-write r1; a $400B write lands after
    // quarter-frame processing so qf sees the old reload flag.
    always_comb begin
        addr        = reg_addr_e'(wr_addr);
        wr_len      = wr_en && (addr == REG_LEN_HI);
        lin_next    = lin_cnt;
        reload_next = reload_flag;
        len_next    = len_cnt;

        if (qf) begin
            if (reload_flag) begin
                lin_next = r1[6:0];
            end else if (lin_cnt != '0) begin
                lin_next = lin_cnt - 7'd1;
            end
            if (!r1[7]) begin
                reload_next = 1'b0;
            end
        end
        if (wr_len) begin
            reload_next = 1'b1;
        end

        if (!ch_en) begin
            len_next = '0;
        end else if (wr_len) begin
            len_next = len_lookup(wr_data[7:3]);
        end else if (hf && !r1[7] && (len_cnt != '0)) begin
            len_next = len_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r1          <= '0;
            r3          <= '0;
            r4          <= '0;
            lin_cnt     <= '0;
            len_cnt     <= '0;
            reload_flag <= 1'b0;
            step_en     <= 1'b0;
            len_active  <= 1'b0;
        end else begin
            lin_cnt     <= lin_next;
            len_cnt     <= len_next;
            reload_flag <= reload_next;
            step_en     <= (lin_cnt != '0) && (len_cnt != '0);
            len_active  <= (len_cnt != '0);
            if (wr_en) begin
                case (addr)
                    REG_LINEAR:   r1 <= wr_data;
                    REG_TIMER_LO: r3 <= wr_data;
                    REG_LEN_HI:   r4 <= wr_data;
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tri_gate_ctrl.sv
// Bench for tri_gate_ctrl: directed APU scenarios plus random traffic checked
// every cycle against a behavioural model of the triangle gating rules.
`timescale 1ns/1ps
module tb_tri_gate_ctrl;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       wr_en      = 1'b0;
    logic [1:0] wr_addr    = 2'd0;
    logic [7:0] wr_data    = 8'd0;
    logic       ch_en      = 1'b1;
    logic       frame_mode = 1'b1;
    logic [7:0] r1, r3, r4;
    logic       step_en, len_active, qf, hf;
    logic [6:0] lin_cnt;

    int checks   = 0;
    int failures = 0;

    int len_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                         12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    // Model state: values visible during the current cycle.
    int m_pos = 0, m_lin = 0, m_len = 0, m_r1 = 0, m_r3 = 0, m_r4 = 0;
    bit m_mode = 0, m_reload = 0, m_qf = 0, m_hf = 0, m_step = 0, m_act = 0;

    tri_gate_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ch_en      (ch_en),
        .frame_mode (frame_mode),
        .r1         (r1),
        .r3         (r3),
        .r4         (r4),
        .step_en    (step_en),
        .len_active (len_active),
        .qf         (qf),
        .hf         (hf),
        .lin_cnt    (lin_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int  t_end;
        bit  n_qf, n_hf, n_step, n_act, len_wr;
        if (reset) begin
            m_pos = 0; m_lin = 0; m_len = 0; m_reload = 0;
            m_r1 = 0; m_r3 = 0; m_r4 = 0;
            m_qf = 0; m_hf = 0; m_step = 0; m_act = 0;
            return;
        end
        if (m_pos == 0) m_mode = frame_mode;
        t_end  = m_mode ? 37281 : 29829;
        n_hf   = (m_pos == 14913) || (m_pos == t_end);
        n_qf   = n_hf || (m_pos == 7457) || (m_pos == 22371);
        n_step = (m_lin != 0) && (m_len != 0);
        n_act  = (m_len != 0);
        len_wr = wr_en && (wr_addr == 2'd3);
        if (m_qf) begin
            if (m_reload) m_lin = m_r1 % 128;
            else if (m_lin > 0) m_lin = m_lin - 1;
            if (m_r1 < 128) m_reload = 0;
        end
        if (len_wr) m_reload = 1;
        if (!ch_en) m_len = 0;
        else if (len_wr) m_len = len_tab[int'(wr_data) / 8];
        else if (m_hf && m_r1 < 128 && m_len > 0) m_len = m_len - 1;
        if (wr_en) begin
            if (wr_addr == 2'd0) m_r1 = int'(wr_data);
            if (wr_addr == 2'd2) m_r3 = int'(wr_data);
            if (wr_addr == 2'd3) m_r4 = int'(wr_data);
        end
        m_pos  = (m_pos == t_end) ? 0 : m_pos + 1;
        m_qf   = n_qf;
        m_hf   = n_hf;
        m_step = n_step;
        m_act  = n_act;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        logic [34:0] act_v, exp_v;
        @(negedge clk);
        act_v = {qf, hf, step_en, len_active, lin_cnt, r1, r3, r4};
        exp_v = {m_qf, m_hf, m_step, m_act, 7'(m_lin), 8'(m_r1), 8'(m_r3), 8'(m_r4)};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL outputs t=%0t pos=%0d actual={qf,hf,step,act,lin,r1,r3,r4}=%h required=%h",
                     $time, m_pos, act_v, exp_v);
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s pos=%0d actual=%0d required=%0d", name, m_pos, act, exp);
        end
    endtask

    task automatic filler();
        wr_en = 1'b0;
        if ($urandom_range(15) == 0) begin
            wr_en   = 1'b1;
            wr_addr = ($urandom_range(1) == 1) ? 2'd2 : 2'd1;
            wr_data = 8'($urandom);
        end
    endtask

    task automatic wait_pos(input int pos);
        int n = 0;
        do begin
            @(negedge clk);
            filler();
            n++;
        end while (m_pos != pos && n < 40000);
        if (m_pos != pos) begin
            checks++;
            failures++;
            $display("FAIL wait_pos actual=%0d required=%0d", m_pos, pos);
        end
    endtask

    task automatic write_at(input int pos, input logic [1:0] a, input logic [7:0] d);
        wait_pos(pos);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        lit("reset_lin", int'(lin_cnt), 0);
        lit("reset_step_en", int'(step_en), 0);
        lit("reset_len_active", int'(len_active), 0);
        lit("reset_r4", int'(r4), 0);
        reset = 1'b0;

        // 5-step sequence; load $4008=0x05 then $400B index 1.
        write_at(1, 2'd0, 8'h05);
        write_at(3, 2'd3, 8'h08);
        wait_pos(4);
        lit("model_len_load", m_len, 254);
        lit("model_reload_set", int'(m_reload), 1);
        wait_pos(5);
        lit("len_active_after_load", int'(len_active), 1);
        wait_pos(7000);
        lit("step_en_before_qf", int'(step_en), 0);
        wait_pos(7459);
        lit("lin_first_qf", int'(lin_cnt), 5);
        wait_pos(7460);
        lit("step_en_after_qf", int'(step_en), 1);
        wait_pos(14915);
        lit("lin_qf2", int'(lin_cnt), 4);
        lit("model_len_hf1", m_len, 253);
        wait_pos(20000);
        frame_mode = 1'b0;
        wait_pos(22373);
        lit("lin_qf3", int'(lin_cnt), 3);
        wait_pos(29830);
        lit("no_qf_29829_5step", int'(qf), 0);
        lit("no_hf_29829_5step", int'(hf), 0);
        wait_pos(0);
        lit("qf_37281", int'(qf), 1);
        lit("hf_37281", int'(hf), 1);
        wait_pos(1);
        lit("lin_qf4", int'(lin_cnt), 2);
        lit("model_len_hf2", m_len, 252);

        // 4-step sequence: linear counter runs out.
        wait_pos(7459);
        lit("lin_qf5", int'(lin_cnt), 1);
        wait_pos(14915);
        lit("lin_zero", int'(lin_cnt), 0);
        wait_pos(14916);
        lit("step_en_falls", int'(step_en), 0);

        // $400B write coincident with hf/qf from count 29829.
        wait_pos(0);
        lit("hf_29829_4step", int'(hf), 1);
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h08;
        wait_pos(1);
        lit("model_len_load_wins", m_len, 254);
        lit("lin_old_reload", int'(lin_cnt), 0);
        lit("model_reload_after", int'(m_reload), 1);

        // Control bit set: reload every qf, length halted.
        write_at(100, 2'd0, 8'h85);
        wait_pos(7459);
        lit("lin_ctrl_qf1", int'(lin_cnt), 5);
        wait_pos(14915);
        lit("lin_ctrl_qf2", int'(lin_cnt), 5);
        lit("step_en_ctrl", int'(step_en), 1);
        lit("model_len_halted", m_len, 254);

        // Channel disable.
        write_at(14930, 2'd3, 8'h10);
        wait_pos(14932);
        lit("model_len_20", m_len, 20);
        wait_pos(14940);
        ch_en = 1'b0;
        wait_pos(14941);
        lit("model_len_forced0", m_len, 0);
        wait_pos(14942);
        lit("len_active_drop", int'(len_active), 0);
        write_at(14950, 2'd3, 8'h08);
        wait_pos(14952);
        lit("model_len_write_disabled", m_len, 0);
        lit("len_active_write_disabled", int'(len_active), 0);
        ch_en = 1'b1;

        // Random traffic, with a reset pulse colliding with a $400B write.
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (i == 7902) begin
                lit("post_reset_lin", int'(lin_cnt), 0);
                lit("post_reset_r4", int'(r4), 0);
                lit("post_reset_len_active", int'(len_active), 0);
            end
            wr_en      = ($urandom_range(7) == 0);
            wr_addr    = 2'($urandom);
            wr_data    = 8'($urandom);
            ch_en      = ($urandom_range(99) != 0);
            frame_mode = 1'($urandom);
            reset      = (i == 7900) || (i == 7901);
            if (i == 7900) begin
                wr_en   = 1'b1;
                wr_addr = 2'd3;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
